fir_sample_feeder: RTL

- Upstream front end of the FIR filter. Sits between the host strobes and the FIR controller.
- Captures incoming samples and coefficients, and queues samples in a 2-entry buffer.
- Drives the controller's dr and lc handshakes, holding each request for exactly as long as the controller needs it. Paces on the controller's modwait.
- Flags dropped samples and controller handshake timeouts.

---
 rtl/fir_sample_feeder_pkg.sv | 30 +++
 rtl/fir_sample_feeder_if.sv | 37 +++
 rtl/fir_sample_fifo.sv | 73 +++++++
 rtl/fir_sample_feeder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fir_sample_feeder_pkg.sv
// ---------------------------------------------------------------------------
// fir_feeder_pkg : shared types and defaults for the FIR sample feeder. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fir_feeder_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_NUM_COEFF = 4;
  localparam int DEF_TIMEOUT   = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SREQ  = 3'd1,
    ST_SHOLD = 3'd2,
    ST_SBUSY = 3'd3,
    ST_CREQ  = 3'd4,
    ST_CHOLD = 3'd5,
    ST_CBUSY = 3'd6,
    ST_ERR   = 3'd7
  } feeder_state_e;

  // A single-entry coefficient table still needs one index bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_sample_feeder_if.sv
// ---------------------------------------------------------------------------
// fir_sample_feeder_if : host strobes in, controller handshake out. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fir_sample_feeder_if #(
  parameter int DATA_W = fir_feeder_pkg::DEF_DATA_W,
  parameter int IDX_W  = fir_feeder_pkg::idx_width(fir_feeder_pkg::DEF_NUM_COEFF)
);

  logic              data_ready_in;
  logic              load_coeff_in;
  logic [DATA_W-1:0] sample_in;
  logic [DATA_W-1:0] coeff_in;
  logic              modwait;
  logic              dr;
  logic              lc;
  logic [DATA_W-1:0] sample_out;
  logic [DATA_W-1:0] coeff_out;
  logic [IDX_W-1:0]  coeff_index;
  logic              pending;
  logic              drop_err;
  logic              timeout_err;

  modport master (
    output data_ready_in, load_coeff_in, sample_in, coeff_in, modwait,
    input  dr, lc, sample_out, coeff_out, coeff_index, pending, drop_err, timeout_err
  );

  modport slave (
    input  data_ready_in, load_coeff_in, sample_in, coeff_in, modwait,
    output dr, lc, sample_out, coeff_out, coeff_index, pending, drop_err, timeout_err
  );

endinterface

`default_nettype wire

// File: rtl/fir_sample_fifo.sv
// ---------------------------------------------------------------------------
// fir_sample_fifo : 2-entry sample buffer, push/pop/flush with count. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir_sample_fifo #(
  parameter int DATA_W = fir_feeder_pkg::DEF_DATA_W
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              push_i,
  input  wire logic              pop_i,
  input  wire logic              flush_i,
  input  wire logic [DATA_W-1:0] data_i,
  output logic      [DATA_W-1:0] data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic      [1:0]        count_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              w_push_ok;
  logic              w_pop_ok;

  // A pop in the same cycle frees the slot, so a push at full is still taken.
  assign w_pop_ok  = pop_i & (count_q != 2'd0);
  assign w_push_ok = push_i & ((count_q != 2'd2) | w_pop_ok);

  always_comb begin
    count_d = count_q;
    if (w_push_ok && !w_pop_ok) begin
      count_d = count_q + 2'd1;
    end else if (!w_push_ok && w_pop_ok) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (w_push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (w_pop_ok) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fir_sample_feeder.sv
// ---------------------------------------------------------------------------
// fir_sample_feeder : FIR front end; strobe capture, sample FIFO, dr/lc handshake. Rev 1.0
// Optional macro SYNC_INPUTS_EN: 2-flop strobe synchronizers plus matched data delay.
// ---------------------------------------------------------------------------
`default_nettype none

module fir_sample_feeder
  import fir_feeder_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_COEFF = DEF_NUM_COEFF,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input wire logic           clk,
  input wire logic           rst,
  fir_sample_feeder_if.slave feeder_io
);

  localparam int IDX_W = idx_width(NUM_COEFF);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic              w_dr_strobe;
  logic              w_lc_strobe;
  logic [DATA_W-1:0] w_sample;
  logic [DATA_W-1:0] w_coeff;

`ifdef SYNC_INPUTS_EN
  logic [1:0]             dr_sync_q;
  logic [1:0]             lc_sync_q;
  logic [1:0][DATA_W-1:0] sample_dly_q;
  logic [1:0][DATA_W-1:0] coeff_dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dr_sync_q    <= '0;
      lc_sync_q    <= '0;
      sample_dly_q <= '0;
      coeff_dly_q  <= '0;
    end else begin
      dr_sync_q    <= {dr_sync_q[0], feeder_io.data_ready_in};
      lc_sync_q    <= {lc_sync_q[0], feeder_io.load_coeff_in};
      sample_dly_q <= {sample_dly_q[0], feeder_io.sample_in};
      coeff_dly_q  <= {coeff_dly_q[0], feeder_io.coeff_in};
    end
  end

  assign w_dr_strobe = dr_sync_q[1];
  assign w_lc_strobe = lc_sync_q[1];
  assign w_sample    = sample_dly_q[1];
  assign w_coeff     = coeff_dly_q[1];
`else
  assign w_dr_strobe = feeder_io.data_ready_in;
  assign w_lc_strobe = feeder_io.load_coeff_in;
  assign w_sample    = feeder_io.sample_in;
  assign w_coeff     = feeder_io.coeff_in;
`endif

  logic              dr_prev_q;
  logic              lc_prev_q;
  logic              dr_req_q;
  logic              lc_req_q;
  logic [DATA_W-1:0] sample_hold_q;
  logic [DATA_W-1:0] coeff_hold_q;

  // Edge requests are registered with their data; this is the first latency stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      dr_prev_q     <= 1'b0;
      lc_prev_q     <= 1'b0;
      dr_req_q      <= 1'b0;
      lc_req_q      <= 1'b0;
      sample_hold_q <= '0;
      coeff_hold_q  <= '0;
    end else begin
      dr_prev_q <= w_dr_strobe;
      lc_prev_q <= w_lc_strobe;
      dr_req_q  <= w_dr_strobe & ~dr_prev_q;
      lc_req_q  <= w_lc_strobe & ~lc_prev_q;
      if (w_dr_strobe && !dr_prev_q) begin
        sample_hold_q <= w_sample;
      end
      if (w_lc_strobe && !lc_prev_q) begin
        coeff_hold_q <= w_coeff;
      end
    end
  end

  logic              w_pop;
  logic              w_to_err;
  logic              w_coeff_done;
  logic              w_full;
  logic              w_empty;
  logic [1:0]        w_count;
  logic [DATA_W-1:0] w_head;

  fir_sample_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (dr_req_q),
    .pop_i   (w_pop),
    .flush_i (w_to_err),
    .data_i  (sample_hold_q),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  logic [DATA_W-1:0] coeff_q;
  logic              coeff_pend_q;
  logic [IDX_W-1:0]  coeff_idx_q;
  logic              w_sample_drop;
  logic              w_coeff_drop;

  assign w_sample_drop = dr_req_q & w_full & ~w_pop & ~w_to_err;
  assign w_coeff_drop  = lc_req_q & coeff_pend_q & ~w_coeff_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      coeff_q      <= '0;
      coeff_pend_q <= 1'b0;
      coeff_idx_q  <= '0;
    end else begin
      if (lc_req_q) begin
        coeff_q      <= coeff_hold_q;
        coeff_pend_q <= 1'b1;
      end else if (w_coeff_done || w_to_err) begin
        coeff_pend_q <= 1'b0;
      end
      if (w_coeff_done) begin
        coeff_idx_q <= (coeff_idx_q == IDX_W'(NUM_COEFF - 1)) ? '0 : coeff_idx_q + IDX_W'(1);
      end
    end
  end

  feeder_state_e    state_q;
  feeder_state_e    state_d;
  logic [CNT_W-1:0] wait_cnt_q;
  logic [CNT_W-1:0] wait_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    w_pop        = 1'b0;
    w_to_err     = 1'b0;
    w_coeff_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (coeff_pend_q) begin
          state_d = ST_CREQ;
        end else if (!w_empty && !feeder_io.modwait) begin
          state_d = ST_SREQ;
        end
      end
      ST_SREQ, ST_CREQ: begin
        if (feeder_io.modwait) begin
          state_d = (state_q == ST_SREQ) ? ST_SHOLD : ST_CHOLD;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d  = ST_ERR;
          w_to_err = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_SHOLD: state_d = ST_SBUSY;
      ST_CHOLD: state_d = ST_CBUSY;
      ST_SBUSY: begin
        if (!feeder_io.modwait) begin
          w_pop   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_CBUSY: begin
        if (!feeder_io.modwait) begin
          w_coeff_done = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  logic drop_err_q;
  logic timeout_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      drop_err_q    <= drop_err_q | w_sample_drop | w_coeff_drop;
      timeout_err_q <= timeout_err_q | w_to_err;
    end
  end

  assign feeder_io.dr          = (state_q == ST_SREQ) || (state_q == ST_SHOLD);
  assign feeder_io.lc          = (state_q == ST_CREQ) || (state_q == ST_CHOLD);
  assign feeder_io.sample_out  = w_head;
  assign feeder_io.coeff_out   = coeff_q;
  assign feeder_io.coeff_index = coeff_idx_q;
  assign feeder_io.pending     = (w_count != 2'd0);
  assign feeder_io.drop_err    = drop_err_q;
  assign feeder_io.timeout_err = timeout_err_q;

endmodule

`default_nettype wire
